// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: parity modes, FSM state
// encoding and a width helper for the per-bit cycle counter.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // A counter for n states needs at least one bit, even when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth. Pointers wrap naturally, and
// the occupancy count distinguishes full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A push while full or a pop while empty is simply not performed.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array has no reset; pointers and count alone decide
  // which entries are valid, so clearing the data would only cost area.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. Frames are sent back to back while
// words are queued; tx is a register driven from the next-state values.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          write_en,
  output logic                          rdy,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = 4;
  localparam logic [CNT_W-1:0] LAST_TICK  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD_INVERT = (PARITY == PARITY_ODD);
  localparam logic             HAS_PARITY = (PARITY != PARITY_NONE);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;

  logic                 pop;
  logic                 bit_done;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (write_en),
    .pop     (pop),
    .wr_data (data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bit_done = (bit_cnt_q == LAST_TICK);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state logic; pop doubles as the "load a new frame" strobe.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    pop       = 1'b0;

    if (state_q != ST_IDLE) begin
      bit_cnt_d = bit_done ? '0 : bit_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (idx_q == LAST_DATA) begin
            state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (idx_q == LAST_STOP) begin
            if (fifo_empty) begin
              state_d = ST_IDLE;
            end else begin
              pop = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      state_d   = ST_START;
      bit_cnt_d = '0;
      idx_d     = '0;
      shift_d   = fifo_rd_data;
      parity_d  = (^fifo_rd_data) ^ ODD_INVERT;
    end
  end

  // Output logic: the line level that goes with the state being entered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign rdy  = !fifo_full;
  assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Drives four differently configured transmitters with shared stimulus and
// compares every output, every cycle, against a queue-based frame model.
module tb_uart_tx_fifo;

  localparam int NU = 4;
  localparam int DB  [NU] = '{8, 7, 8, 5};
  localparam int CPB [NU] = '{16, 1, 2, 3};
  localparam int PAR [NU] = '{0, 2, 1, 2};
  localparam int STB [NU] = '{1, 1, 2, 2};
  localparam int DEP [NU] = '{4, 4, 4, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       write_en = 1'b0;
  logic [8:0] data = '0;
  logic       chk_en = 1'b0;

  logic       tx_w   [NU];
  logic       rdy_w  [NU];
  logic       busy_w [NU];
  logic [2:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(DB[0]), .CLKS_PER_BIT(CPB[0]), .PARITY(PAR[0]),
                 .STOP_BITS(STB[0]), .FIFO_DEPTH(DEP[0])) u0 (
    .clk(clk), .rst(rst), .data(data[DB[0]-1:0]), .write_en(write_en),
    .rdy(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt0));

  uart_tx_fifo #(.DATA_BITS(DB[1]), .CLKS_PER_BIT(CPB[1]), .PARITY(PAR[1]),
                 .STOP_BITS(STB[1]), .FIFO_DEPTH(DEP[1])) u1 (
    .clk(clk), .rst(rst), .data(data[DB[1]-1:0]), .write_en(write_en),
    .rdy(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt1));

  uart_tx_fifo #(.DATA_BITS(DB[2]), .CLKS_PER_BIT(CPB[2]), .PARITY(PAR[2]),
                 .STOP_BITS(STB[2]), .FIFO_DEPTH(DEP[2])) u2 (
    .clk(clk), .rst(rst), .data(data[DB[2]-1:0]), .write_en(write_en),
    .rdy(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt2));

  uart_tx_fifo #(.DATA_BITS(DB[3]), .CLKS_PER_BIT(CPB[3]), .PARITY(PAR[3]),
                 .STOP_BITS(STB[3]), .FIFO_DEPTH(DEP[3])) u3 (
    .clk(clk), .rst(rst), .data(data[DB[3]-1:0]), .write_en(write_en),
    .rdy(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a queue of words waiting, and a queue of line levels,
  // one entry per clock cycle, for the frame currently being sent.
  int unsigned mq [NU][$];
  bit          lq [NU][$];

  task automatic add_bits(input int u, input bit b, input int n);
    for (int i = 0; i < n; i++) lq[u].push_back(b);
  endtask

  task automatic build_frame(input int u, input int unsigned w);
    bit p;
    p = 1'b0;
    add_bits(u, 1'b0, CPB[u]);
    for (int i = 0; i < DB[u]; i++) begin
      add_bits(u, w[i], CPB[u]);
      p = p ^ w[i];
    end
    if (PAR[u] == 1) add_bits(u, ~p, CPB[u]);
    if (PAR[u] == 2) add_bits(u, p, CPB[u]);
    add_bits(u, 1'b1, STB[u] * CPB[u]);
  endtask

  task automatic model_edge(input int u);
    bit          was_full;
    int unsigned w;
    if (rst) begin
      mq[u].delete();
      lq[u].delete();
    end else begin
      was_full = (mq[u].size() >= DEP[u]);
      if (lq[u].size() > 0) void'(lq[u].pop_front());
      if (lq[u].size() == 0 && mq[u].size() > 0) begin
        w = mq[u].pop_front();
        build_frame(u, w);
      end
      if (write_en && !was_full)
        mq[u].push_back(int'(data) & ((1 << DB[u]) - 1));
    end
  endtask

  always @(posedge clk) begin
    for (int u = 0; u < NU; u++) model_edge(u);
  end

  function automatic logic [31:0] dut_cnt(input int u);
    case (u)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      2:       return 32'(cnt2);
      default: return 32'(cnt3);
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < NU; u++) begin
        check($sformatf("u%0d.tx", u), 32'(tx_w[u]),
              (lq[u].size() > 0) ? 32'(lq[u][0]) : 32'd1);
        check($sformatf("u%0d.count", u), dut_cnt(u), 32'(mq[u].size()));
        check($sformatf("u%0d.rdy", u), 32'(rdy_w[u]),
              32'(mq[u].size() < DEP[u]));
        check($sformatf("u%0d.busy", u), 32'(busy_w[u]),
              32'(lq[u].size() > 0 || mq[u].size() > 0));
      end
    end
  end

  task automatic tick(input bit we, input logic [8:0] d, input bit r);
    @(negedge clk);
    rst      = r;
    write_en = we;
    data     = d;
  endtask

  function automatic logic any_busy();
    logic b;
    b = 1'b0;
    for (int u = 0; u < NU; u++) b = b | busy_w[u];
    return b;
  endfunction

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!any_busy()) break;
      tick(1'b0, '0, 1'b0);
    end
    check("wait_idle", 32'(any_busy()), 32'd0);
  endtask

  initial begin
    logic [9:0] seq;

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    tick(1'b1, 9'h0AA, 1'b1);
    tick(1'b0, '0, 1'b0);
    check("rst.tx", 32'(tx_w[0]), 32'd1);
    check("rst.count", dut_cnt(0), 32'd0);

    // 7 data bits, even parity, one cycle per bit
    tick(1'b1, 9'h003, 1'b0);
    tick(1'b0, '0, 1'b0);
    seq = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, '0, 1'b0);
      seq[i] = tx_w[1];
    end
    check("u1.frame", 32'(seq), 32'(10'b1000000110));
    tick(1'b0, '0, 1'b0);
    check("u1.idle", 32'(busy_w[1]), 32'd0);
    wait_idle(1000);

    // Default configuration, 0x55, sampled mid-bit
    tick(1'b1, 9'h055, 1'b0);
    tick(1'b0, '0, 1'b0);
    seq = '0;
    for (int c = 0; c < 160; c++) begin
      tick(1'b0, '0, 1'b0);
      if (c % 16 == 8) seq[c / 16] = tx_w[0];
    end
    check("u0.frame55", 32'(seq), 32'(10'b1010101010));
    tick(1'b0, '0, 1'b0);
    check("u0.busy_after", 32'(busy_w[0]), 32'd0);
    check("u0.tx_after", 32'(tx_w[0]), 32'd1);
    wait_idle(1000);

    // Six back-to-back writes: five accepted, sixth dropped
    for (int i = 0; i < 6; i++) tick(1'b1, 9'($urandom), 1'b0);
    tick(1'b0, '0, 1'b0);
    check("u0.full_count", dut_cnt(0), 32'd4);
    check("u0.full_rdy", 32'(rdy_w[0]), 32'd0);
    check("u3.full_count", dut_cnt(3), 32'd2);
    wait_idle(3000);

    // Reset in the middle of data bit 3 with words queued
    for (int i = 0; i < 3; i++) tick(1'b1, 9'($urandom), 1'b0);
    tick(1'b0, '0, 1'b0);
    repeat (68) tick(1'b0, '0, 1'b0);
    tick(1'b1, 9'h1FF, 1'b1);
    tick(1'b0, '0, 1'b0);
    check("mid_rst.tx", 32'(tx_w[0]), 32'd1);
    check("mid_rst.count", dut_cnt(0), 32'd0);
    check("mid_rst.rdy", 32'(rdy_w[0]), 32'd1);
    tick(1'b1, 9'h03C, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    check("clean.start", 32'(tx_w[0]), 32'd0);
    wait_idle(1000);

    // Random traffic with occasional resets
    for (int c = 0; c < 6000; c++) begin
      tick(($urandom_range(0, 5) == 0), 9'($urandom), ($urandom_range(0, 799) == 0));
    end
    tick(1'b0, '0, 1'b0);
    wait_idle(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL expose parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..9).
REQ-002 The block SHALL expose parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (legal range >=1).
REQ-003 The block SHALL expose parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 The block SHALL expose parameter STOP_BITS, default 1, meaning stop bits per frame (1 or 2).
REQ-005 The block SHALL expose parameter FIFO_DEPTH, default 4, meaning queued words (power of two, >=2).
REQ-006 The block SHALL have one clock and a synchronous, active-high reset.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 data  input  DATA_BITS  word to queue.
REQ-010 write_en  input  1  write request; accepted on an edge where write_en=1 and rdy=1.
REQ-011 rdy  output  1  high when the FIFO is not full.
REQ-012 tx  output  1  registered serial line; idles high.
REQ-013 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently queued.

Function
REQ-015 Frame SHALL be: start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
REQ-016 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, timed by a bit counter that wraps from CLKS_PER_BIT-1 to 0.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-018 IDLE->START SHALL occur on the edge after the FIFO becomes non-empty; the head word is popped on that same edge.
REQ-019 A write captured at edge k into an empty FIFO with the FSM in IDLE SHALL put tx low after edge k+1.
REQ-020 DATA->PARITY/STOP SHALL occur after bit DATA_BITS-1 has completed; STOP completes after STOP_BITS*CLKS_PER_BIT cycles.
REQ-021 At end of STOP, the FSM SHALL go to START directly (no idle cycle) if the FIFO is non-empty, else to IDLE.
REQ-022 Even parity SHALL be the XOR of the data bits; odd parity SHALL be its inverse.
REQ-023 A write while full (rdy=0) SHALL be ignored; queued data and fifo_count are unchanged.
REQ-024 A simultaneous write and pop SHALL both take effect, leaving fifo_count unchanged.
REQ-025 rdy SHALL deassert on the edge fifo_count reaches FIFO_DEPTH and reassert on the edge of the next pop.
REQ-026 Words SHALL be transmitted in write order; FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-027 While rst=1 at an edge, the block SHALL set tx=1, rdy=1, busy=0, fifo_count=0, state IDLE, and clear counters.
REQ-028 Reset mid-frame SHALL abort the frame and discard all queued words; tx is high after that edge.
REQ-029 A write_en asserted on a reset edge SHALL be ignored.

Structure
REQ-030 Package uart_pkg SHALL hold the parity-mode constants (PARITY_NONE/ODD/EVEN) and the FSM state encoding.
REQ-031 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, count).
REQ-032 The top SHALL contain the FSM, bit counter, data-bit index, shift register and tx register.

Verification
REQ-033 Defaults, write 0x55 once -> tx low for 16 cycles, then 1,0,1,0,1,0,1,0 for 16 cycles each, then high; busy=0 after the stop bit.
REQ-034 PARITY=2, DATA_BITS=7, CLKS_PER_BIT=1, write 0x03 -> tx sequence 0,1,1,0,0,0,0,0,0(parity),1.
REQ-035 PARITY=1, STOP_BITS=2, CLKS_PER_BIT=2, write 0xFF -> parity bit 1, stop held 4 cycles.
REQ-036 FIFO_DEPTH=4, write 6 words back-to-back -> first 5 accepted (one popped), rdy=0, 6th dropped; 5 frames with no idle gap between them.
REQ-037 rst pulsed during data bit 3 -> tx=1, fifo_count=0, rdy=1 after that edge; the next write starts a clean frame.
REQ-038 With fifo_count=2 and mid-frame, write at the edge a pop occurs -> fifo_count stays 2 and rdy stays 1.
